// File: rtl/router_pkt_src.sv
// Store-and-forward packet source for the router input port: buffers a whole
// payload, then sends header, payload and parity under busy back-pressure.
module router_pkt_src #(
   parameter int MAX_LEN  = 63,
   parameter int IDLE_GAP = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_addr,
   input  logic [5:0]       req_len,
   input  logic             pay_valid,
   output logic             pay_ready,
   input  logic [7:0]       pay_data,
   input  logic             busy,
   input  logic             error,
   output logic             pkt_valid,
   output logic [7:0]       data_out,
   output logic             tx_done,
   output logic             tx_err,
   output logic             bad_req,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_HEADER  = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_PARITY  = 3'd4,
      ST_GAP     = 3'd5
   } state_t;

   function automatic logic [7:0] par_fold(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   state_t           state_r;
   logic [1:0]       addr_r;
   logic [5:0]       len_r;
   logic [5:0]       wptr_r;
   logic [5:0]       rptr_r;
   logic [7:0]       parity_r;
   logic [GAP_W-1:0] gap_cnt_r;
   logic             err_seen_r;
   logic             pkt_valid_r;
   logic [7:0]       data_out_r;
   logic             tx_done_r;
   logic             tx_err_r;
   logic             bad_req_r;
   logic [CNT_W-1:0] pkt_count_r;
   logic [CNT_W-1:0] err_count_r;
   logic [7:0]       mem_r [0:MAX_LEN-1];

   logic             pay_accept_s;
   logic [7:0]       hdr_s;
   logic             err_flag_s;

   assign req_ready    = (state_r == ST_IDLE);
   assign pay_ready    = (state_r == ST_LOAD);
   assign pay_accept_s = (state_r == ST_LOAD) && pay_valid;
   assign hdr_s        = {len_r, addr_r};
   assign err_flag_s   = err_seen_r | error;

   assign pkt_valid = pkt_valid_r;
   assign data_out  = data_out_r;
   assign tx_done   = tx_done_r;
   assign tx_err    = tx_err_r;
   assign bad_req   = bad_req_r;
   assign pkt_count = pkt_count_r;
   assign err_count = err_count_r;

   // Payload buffer write port; contents are meaningless until a LOAD completes.
   always_ff @(posedge clock) begin
      if (pay_accept_s) begin
         mem_r[wptr_r] <= pay_data;
      end
   end

   // Transmit FSM with registered router-side outputs and statistics.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         addr_r      <= 2'd0;
         len_r       <= 6'd0;
         wptr_r      <= 6'd0;
         rptr_r      <= 6'd0;
         parity_r    <= 8'd0;
         gap_cnt_r   <= '0;
         err_seen_r  <= 1'b0;
         pkt_valid_r <= 1'b0;
         data_out_r  <= 8'd0;
         tx_done_r   <= 1'b0;
         tx_err_r    <= 1'b0;
         bad_req_r   <= 1'b0;
         pkt_count_r <= '0;
         err_count_r <= '0;
      end else begin
         tx_done_r <= 1'b0;
         bad_req_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  if (req_addr == 2'd3 || req_len == 6'd0) begin
                     bad_req_r <= 1'b1;
                  end else begin
                     addr_r   <= req_addr;
                     len_r    <= req_len;
                     parity_r <= 8'd0;
                     wptr_r   <= 6'd0;
                     state_r  <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (pay_valid) begin
                  wptr_r <= wptr_r + 6'd1;
                  if (wptr_r == len_r - 6'd1) begin
                     // Header is folded in here so parity is final before PAYLOAD.
                     parity_r    <= par_fold(par_fold(parity_r, pay_data), hdr_s);
                     data_out_r  <= hdr_s;
                     pkt_valid_r <= 1'b1;
                     rptr_r      <= 6'd0;
                     state_r     <= ST_HEADER;
                  end else begin
                     parity_r <= par_fold(parity_r, pay_data);
                  end
               end
            end
            ST_HEADER: begin
               if (!busy) begin
                  data_out_r <= mem_r[6'd0];
                  state_r    <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (!busy) begin
                  if (rptr_r == len_r - 6'd1) begin
                     data_out_r  <= parity_r;
                     pkt_valid_r <= 1'b0;
                     state_r     <= ST_PARITY;
                  end else begin
                     rptr_r     <= rptr_r + 6'd1;
                     data_out_r <= mem_r[rptr_r + 6'd1];
                  end
               end
            end
            ST_PARITY: begin
               if (!busy) begin
                  data_out_r <= 8'd0;
                  gap_cnt_r  <= '0;
                  err_seen_r <= 1'b0;
                  state_r    <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt_r == GAP_LAST && !busy) begin
                  tx_done_r   <= 1'b1;
                  tx_err_r    <= err_flag_s;
                  pkt_count_r <= pkt_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  err_count_r <= err_count_r + {{(CNT_W-1){1'b0}}, err_flag_s};
                  state_r     <= ST_IDLE;
               end else begin
                  err_seen_r <= err_flag_s;
                  if (gap_cnt_r != GAP_LAST) begin
                     gap_cnt_r <= gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               pkt_valid_r <= 1'b0;
               data_out_r  <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_router_pkt_src.sv
// Directed bench for router_pkt_src: a table of packets plus hand-written
// reset-abort and back-to-back sequences.
module tb_router_pkt_src;

   localparam int IDLE_GAP = 3;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_addr;
   logic [5:0] req_len;
   logic       pay_valid;
   logic       pay_ready;
   logic [7:0] pay_data;
   logic       busy;
   logic       error;
   logic       pkt_valid;
   logic [7:0] data_out;
   logic       tx_done;
   logic       tx_err;
   logic       bad_req;
   logic [7:0] pkt_count;
   logic [7:0] err_count;

   router_pkt_src #(.MAX_LEN(63), .IDLE_GAP(IDLE_GAP), .CNT_W(8)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_len(req_len),
      .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
      .busy(busy), .error(error),
      .pkt_valid(pkt_valid), .data_out(data_out),
      .tx_done(tx_done), .tx_err(tx_err), .bad_req(bad_req),
      .pkt_count(pkt_count), .err_count(err_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] addr;
      logic [5:0] len;
      logic [7:0] start;
      logic [7:0] step;
      int         stall;
      bit         err_gap;
      bit         bad;
      logic [7:0] hdr;
      logic [7:0] par;
   } vec_t;

   vec_t vecs [7];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   exp_pkts = 0;
   int   exp_errs = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Sends one request; abort_at > 0 returns once that many bytes have been
   // presented-and-consumed (header counts as the first), leaving the packet mid-flight.
   task automatic send(input vec_t v, input int abort_at);
      logic [7:0] pay [0:62];
      logic [7:0] exp_byte;
      int idx, stall_left, guard, gap;
      for (int i = 0; i < 63; i++) pay[i] = v.start + v.step * 8'(i);
      @(negedge clock);
      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_addr = v.addr; req_len = v.len;
      @(negedge clock);
      req_valid = 1'b0;
      if (v.bad) begin
         check("bad_req_pulse", bad_req, 1);
         check("bad_stays_idle", req_ready, 1);
         check("bad_no_load", pay_ready, 0);
         @(negedge clock);
         check("bad_req_clear", bad_req, 0);
         check("bad_no_pkt", pkt_valid, 0);
         return;
      end
      check("load_pay_ready", pay_ready, 1);
      for (int i = 0; i < int'(v.len); i++) begin
         pay_valid = 1'b1; pay_data = pay[i];
         @(negedge clock);
      end
      pay_data = 8'hEE;               // held valid outside LOAD; must be ignored
      check("pay_ready_off", pay_ready, 0);
      idx = 0; stall_left = v.stall; guard = 0;
      while (idx <= int'(v.len) + 1 && guard < 300) begin
         exp_byte = (idx == 0) ? v.hdr : ((idx <= int'(v.len)) ? pay[idx-1] : v.par);
         check("data_out", data_out, exp_byte);
         check("pkt_valid", pkt_valid, (idx <= int'(v.len)) ? 1 : 0);
         if (idx == 1 && stall_left > 0) begin
            busy = 1'b1; stall_left--;
         end else begin
            busy = 1'b0; idx++;
         end
         @(negedge clock);
         guard++;
         if (abort_at > 0 && idx == abort_at) return;
      end
      busy = 1'b0;
      check("tx_bytes_timeout", (guard < 300) ? 1 : 0, 1);
      gap = 0;
      error = v.err_gap;
      while (!tx_done && gap < 20) begin
         check("gap_pkt_valid", pkt_valid, 0);
         check("gap_data_out", data_out, 0);
         @(negedge clock);
         error = 1'b0;
         gap++;
      end
      pay_valid = 1'b0;
      exp_pkts++;
      if (v.err_gap) exp_errs++;
      check("gap_cycles", gap, IDLE_GAP);
      check("tx_done", tx_done, 1);
      check("tx_err", tx_err, v.err_gap);
      check("pkt_count", pkt_count, exp_pkts % 256);
      check("err_count", err_count, exp_errs % 256);
      @(negedge clock);
      check("tx_done_pulse", tx_done, 0);
      check("back_to_idle", req_ready, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rises, low_run, done_seen, c;
      logic prev_pv;

      vecs[0] = '{addr:2'd1, len:6'd2,  start:8'hAA, step:8'hAB, stall:0, err_gap:1'b0, bad:1'b0, hdr:8'h09, par:8'hF6};
      vecs[1] = '{addr:2'd1, len:6'd2,  start:8'hAA, step:8'hAB, stall:4, err_gap:1'b0, bad:1'b0, hdr:8'h09, par:8'hF6};
      vecs[2] = '{addr:2'd3, len:6'd5,  start:8'h00, step:8'h00, stall:0, err_gap:1'b0, bad:1'b1, hdr:8'h00, par:8'h00};
      vecs[3] = '{addr:2'd0, len:6'd0,  start:8'h00, step:8'h00, stall:0, err_gap:1'b0, bad:1'b1, hdr:8'h00, par:8'h00};
      vecs[4] = '{addr:2'd2, len:6'd63, start:8'h00, step:8'h01, stall:0, err_gap:1'b1, bad:1'b0, hdr:8'hFE, par:8'hC1};
      vecs[5] = '{addr:2'd0, len:6'd1,  start:8'h3C, step:8'h00, stall:2, err_gap:1'b0, bad:1'b0, hdr:8'h04, par:8'h38};
      vecs[6] = '{addr:2'd2, len:6'd4,  start:8'h10, step:8'h10, stall:1, err_gap:1'b0, bad:1'b0, hdr:8'h12, par:8'h52};

      reset = 1'b1; req_valid = 1'b0; req_addr = 2'd0; req_len = 6'd0;
      pay_valid = 1'b0; pay_data = 8'd0; busy = 1'b0; error = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_pkt_valid", pkt_valid, 0);
      check("rst_data_out", data_out, 0);
      check("rst_pay_ready", pay_ready, 0);
      check("rst_req_ready", req_ready, 1);
      check("rst_tx_done", tx_done, 0);
      check("rst_tx_err", tx_err, 0);
      check("rst_bad_req", bad_req, 0);
      check("rst_counts", {pkt_count, err_count}, 0);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) send(vecs[i], -1);

      // Reset after the 10th payload byte is consumed, away from any clock edge.
      send('{addr:2'd1, len:6'd20, start:8'h01, step:8'h03, stall:0, err_gap:1'b0, bad:1'b0, hdr:8'h51, par:8'h00}, 11);
      check("abort_pre_valid", pkt_valid, 1);
      reset = 1'b1;
      #1;
      check("abort_async_valid", pkt_valid, 0);
      check("abort_data_out", data_out, 0);
      check("abort_idle", req_ready, 1);
      check("abort_counts", {pkt_count, err_count}, 0);
      exp_pkts = 0; exp_errs = 0;
      pay_valid = 1'b0; busy = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      send(vecs[0], -1);

      // Back-to-back: request and payload held valid across two packets.
      req_valid = 1'b1; req_addr = 2'd0; req_len = 6'd1;
      pay_valid = 1'b1; pay_data = 8'h3C; busy = 1'b0;
      rises = 0; low_run = 0; done_seen = 0; prev_pv = 1'b0;
      for (c = 0; c < 40 && rises < 2; c++) begin
         @(negedge clock);
         if (tx_done) done_seen++;
         if (pkt_valid && !prev_pv) begin
            rises++;
            if (rises == 2) begin
               check("b2b_done_before_hdr", done_seen, 1);
               check("b2b_low_run", (low_run >= IDLE_GAP + 1) ? 1 : 0, 1);
               check("b2b_hdr", data_out, 8'h04);
               req_valid = 1'b0; pay_valid = 1'b0;
            end
         end
         if (!pkt_valid) low_run++;
         else low_run = 0;
         prev_pv = pkt_valid;
      end
      req_valid = 1'b0; pay_valid = 1'b0;
      check("b2b_two_headers", rises, 2);
      exp_pkts++;
      for (c = 0; c < 30 && !tx_done; c++) @(negedge clock);
      check("b2b_second_done", tx_done, 1);
      exp_pkts++;
      check("b2b_pkt_count", pkt_count, exp_pkts % 256);
      check("b2b_err_count", err_count, exp_errs % 256);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/router_pkt_src.md
Name: router_pkt_src

Overview:
Packet source that drives the router's input port: pkt_valid, the 8-bit data bus, and the busy/error returns. It accepts a transmit request (destination address and payload length) plus a payload byte stream, and buffers the whole payload (store-and-forward). It then emits header, payload and parity bytes under router back-pressure and checks the router's parity verdict. It is used as the traffic generator in system benches and as the host-side front end of the router.

Parameters:
MAX_LEN, 63, payload buffer depth in bytes; fixed by the 6-bit length field.
IDLE_GAP, 3, minimum number of cycles pkt_valid is held low after a parity byte before the next header.
CNT_W, 8, width of the statistics counters.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
req_valid  in  1  request strobe.
req_ready  out  1  high only in IDLE.
req_addr  in  2  destination port, 0..2.
req_len  in  6  payload length, 1..63.
pay_valid  in  1  payload byte valid.
pay_ready  out  1  payload byte accepted when valid and ready are both high.
pay_data  in  8  payload byte.
busy  in  1  router back-pressure.
error  in  1  router parity-error flag.
pkt_valid  out  1  to router pkt_valid.
data_out  out  8  to router data_in.
tx_done  out  1  one-cycle pulse at the end of GAP.
tx_err  out  1  result of the last packet; updated with tx_done.
bad_req  out  1  one-cycle pulse when an illegal request is dropped.
pkt_count  out  CNT_W  packets sent, wraps.
err_count  out  CNT_W  packets flagged by error, wraps.

Behaviour:
- Reset:
  - State goes to IDLE.
  - pkt_valid=0, data_out=0, pay_ready=0, tx_done=0, tx_err=0, bad_req=0, counters=0.
  - Assertion is asynchronous: pkt_valid drops in the same cycle reset asserts, even mid-packet. The buffer and parity are discarded.
- All outputs are registered except req_ready and pay_ready, which are decoded from state.
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - req_ready=1.
  - On req_valid with req_addr==3 or req_len==0: pulse bad_req next cycle and stay in IDLE.
  - Otherwise latch addr and len, set parity=0, write pointer=0, and go to LOAD.
- LOAD:
  - pay_ready=1 until len bytes are captured.
  - Each accepted byte is written to the buffer and XORed into parity.
  - After the len-th byte, go to HEADER. Once there, data_out={len,addr}, pkt_valid=1, parity^={len,addr}, read pointer=0.
- Transfer rule: the byte on data_out is consumed by the router at a rising edge where busy==0 in HEADER, PAYLOAD or PARITY. While busy==1, data_out and pkt_valid hold unchanged, for any number of cycles.
- HEADER:
  - On consume, data_out=buf[0] and go to PAYLOAD.
- PAYLOAD:
  - pkt_valid stays 1.
  - On consume of byte i<len-1, data_out=buf[i+1].
  - On consume of the last byte, data_out=parity, pkt_valid=0, and go to PARITY.
- PARITY:
  - pkt_valid=0 and data_out=parity.
  - On consume, go to GAP and clear the gap counter and error-seen flag.
- GAP:
  - pkt_valid=0 and data_out=0.
  - Sample error every cycle; any 1 sets error-seen.
  - Leave when gap counter==IDLE_GAP-1 and busy==0. busy==1 extends GAP.
  - On leaving: pulse tx_done, set tx_err=error-seen, pkt_count+=1, err_count+=error-seen, go to IDLE.
- Wire-level parity: XOR of the header byte and all payload bytes, so the XOR of every byte sent on data_out, parity included, is 0.
- Minimum packet time with busy tied low, measured from request accept to tx_done: 1 + len + 1 + len + 1 + IDLE_GAP cycles.
- Counter saturation: counters wrap modulo 2^CNT_W.
- Simultaneous events: req_valid is ignored outside IDLE. pay_valid is ignored outside LOAD; no byte is consumed.
- Back-pressure mid-packet never drops pkt_valid before the last payload byte is consumed.

Test Plan:
1. Basic packet, busy=0: addr=1, len=2, payload 0xAA,0x55.
   -> data_out sequence 0x09, 0xAA, 0x55, 0xF6.
   -> pkt_valid=1 for exactly 3 cycles and low during the 0xF6 cycle.
   -> tx_done after 3 gap cycles; tx_err=0; pkt_count=1.
2. Back-pressure: same packet, busy=1 for 4 cycles while 0xAA is presented.
   -> 0xAA held for 5 cycles, pkt_valid stays 1, sequence otherwise identical.
3. Illegal requests: addr=3, len=5 -> bad_req pulse, no LOAD, pkt_valid never rises. len=0, addr=0 -> same result.
4. Error report: addr=2, len=63 of incrementing bytes, with error driven high for one cycle during GAP.
   -> tx_err=1, err_count=1.
   -> Parity byte equals the XOR of 0xFE and 0x00..0x3E.
5. Reset mid-PAYLOAD: assert reset after the 10th byte is consumed.
   -> pkt_valid=0 in the same cycle, state IDLE, counters 0.
   -> The next request transmits a clean packet.
6. Back-to-back: two requests issued with req_valid held.
   -> Second header appears only after tx_done; gap with pkt_valid=0 is at least 3 cycles plus the parity cycle.
